sig_capture_mram: RTL and testbench
===================================

Name: sig_capture_mram

Overview:
Serial-line capture block; the receive-side counterpart of the ROM-driven signal generator.
- Waits for an armed start, synchronises an external 1-bit line, and detects the first rising edge.
- Samples the line mid-bit at a fixed bit period and packs the samples into W-bit words.
- Stores DEPTH words in an internal RAM, which the bench or a checker reads back through a registered read port.

Parameters:
DIV, 16, clock cycles per bit period (>=4, even)
W, 8, bits per stored word
DEPTH, 16, number of words captured per run
AW, 4, address width, equals clog2(DEPTH)

Ports:
iCLK  in  1  system clock, all logic on rising edge
iRST_N  in  1  asynchronous active-low reset
iSTART  in  1  one-cycle arm pulse; honoured only in IDLE or DONE
iSIG  in  1  asynchronous serial input (e.g. generator oLED)
iRD_ADDR  in  AW  readback address
oRD_DATA  out  W  registered read data, 1-cycle latency
oBUSY  out  1  high in WAIT_EDGE and CAPTURE
oDONE  out  1  high in DONE
oCOUNT  out  AW+1  words written in the current run

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; oBUSY=0, oDONE=0, oCOUNT=0, oRD_DATA=0.
  - Shift register, bit counter and prescaler are cleared.
  - The sync flops are cleared to 0.
  - RAM contents are not cleared.
- Input sync: iSIG passes through 2 flops to give s. A third flop gives s_d. rise = s & ~s_d.
- IDLE:
  - iSTART -> WAIT_EDGE.
  - oCOUNT and the write address are cleared on the transition.
- WAIT_EDGE:
  - rise -> CAPTURE. The prescaler is loaded with DIV/2-1 in the same cycle.
  - A level-high s at arm time does not count as an edge.
- CAPTURE:
  - The prescaler decrements each cycle. At 0 it asserts tick and reloads DIV-1.
  - First tick fires DIV/2 cycles after the rise cycle; each later tick fires DIV cycles after the previous one.
  - On tick: shift = {shift[W-2:0], s}. The first sampled bit ends as the word MSB.
  - On the W-th tick, the completed word is written to mem[wr_addr] in that cycle; wr_addr++ and oCOUNT++.
  - The bit counter resets and capture continues immediately. There is no edge re-sync between words.
  - When oCOUNT reaches DEPTH -> DONE in the cycle after the last write.
- DONE:
  - oDONE=1, and the RAM and oCOUNT are held.
  - iSTART -> WAIT_EDGE; oCOUNT and wr_addr clear.
- iSTART while busy (WAIT_EDGE/CAPTURE) is ignored.
- Read port:
  - oRD_DATA <= mem[iRD_ADDR] every cycle, in all states.
  - Read and write to the same address in the same cycle returns the OLD data (read-before-write).
- Reset asserted mid-CAPTURE:
  - The block returns to IDLE at once and the partial word is discarded.
  - Words already written stay in the RAM.
- Line stuck low or high after the edge: capture still completes on ticks (all-0/all-1 words). No timeout.

Decomposition:
- Shared package/include, cap_defs:
  - state encodings IDLE=2'd0, WAIT_EDGE=2'd1, CAPTURE=2'd2, DONE=2'd3;
  - the default DIV/W/DEPTH constants, shared with the generator bench.
- One sub-module, cap_prescaler:
  - loadable down-counter with load value and load strobe, emitting tick;
  - reused by the generator bench.

Test Plan:
All scenarios use DIV=4, W=8, DEPTH=4.
1. Reset: hold iRST_N=0 with iSIG toggling -> oBUSY=0, oDONE=0, oCOUNT=0. No write occurs even after iSTART is pulsed during reset.
2. Basic capture: pulse iSTART, then drive iSIG with bytes A5,3C,FF,01 MSB-first, 4 clocks/bit, starting with a 0->1 edge. The leading 1 is bit 7 of A5. -> oDONE=1 with oCOUNT=4; reading addresses 0..3 gives A5,3C,FF,01, each appearing 1 cycle after iRD_ADDR is applied.
3. Arm with iSIG already high: hold iSIG=1 for 20 cycles after iSTART -> stays in WAIT_EDGE with oCOUNT=0. Drop iSIG to 0, then raise it -> capture starts.
4. Reset mid-run: assert iRST_N=0 after 1 word plus 3 bits -> IDLE, oCOUNT=0; mem[0] still reads A5.
5. Re-arm from DONE: after scenario 2, pulse iSTART and send 00,11,22,33 -> memory holds the new data and oCOUNT=4. An iSTART pulsed mid-capture has no effect.
6. Read/write collision: hold iRD_ADDR=2 during the write cycle of word 2 -> oRD_DATA shows the old value that cycle and the new value the next cycle.

Source files
------------

// File: rtl/cap_defs.sv
// Shared definitions for the serial capture block and its prescaler.
package cap_defs;

  // Default geometry, shared with the signal generator bench.
  localparam int unsigned DivDef   = 16;
  localparam int unsigned WDef     = 8;
  localparam int unsigned DepthDef = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StWaitEdge = 2'd1,
    StCapture  = 2'd2,
    StDone     = 2'd3
  } cap_state_e;

endpackage

// File: rtl/cap_prescaler.sv
// Loadable down-counter producing a one-cycle tick each time it expires.
module cap_prescaler #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic [Width-1:0] reload_val_i,
  output logic             tick_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load wins over counting; on expiry emit tick and reload the full period.
  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      if (cnt_q == '0) begin
        tick_o = 1'b1;
        cnt_d  = reload_val_i;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sig_capture_mram.sv
// Serial-line capture: waits for a rising edge, samples mid-bit, packs W-bit words into RAM.
module sig_capture_mram
  import cap_defs::*;
#(
  parameter int unsigned DIV   = DivDef,
  parameter int unsigned W     = WDef,
  parameter int unsigned DEPTH = DepthDef,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iSTART,
  input  logic          iSIG,
  input  logic [AW-1:0] iRD_ADDR,
  output logic [W-1:0]  oRD_DATA,
  output logic          oBUSY,
  output logic          oDONE,
  output logic [AW:0]   oCOUNT
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

  // First tick lands DIV/2 cycles after the rise, i.e. mid-bit.
  localparam logic [PW-1:0] HalfLoad  = PW'(DIV / 2 - 1);
  localparam logic [PW-1:0] FullLoad  = PW'(DIV - 1);
  localparam logic [BW-1:0] BitLast   = BW'(W - 1);
  localparam logic [AW:0]   CountLast = (AW + 1)'(DEPTH - 1);

  cap_state_e      state_q, state_d;
  logic [AW:0]     count_q, count_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [W-1:0]    shift_q, shift_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [W-1:0]    rd_data_q, rd_data_d;

  logic            sync1_q, s_q, s_dly_q;
  logic            rise;
  logic            pre_load;
  logic            tick;
  logic            mem_we;
  logic [W-1:0]    word_next;
  logic [W-1:0]    mem [DEPTH];

  // Two-flop synchroniser plus one delay stage for edge detection.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
      s_dly_q <= 1'b0;
    end else begin
      sync1_q <= iSIG;
      s_q     <= sync1_q;
      s_dly_q <= s_q;
    end
  end

  assign rise      = s_q & ~s_dly_q;
  assign word_next = {shift_q[W-2:0], s_q};

  cap_prescaler #(
    .Width (PW)
  ) u_prescaler (
    .clk_i        (iCLK),
    .rst_ni       (iRST_N),
    .en_i         (state_q == StCapture),
    .load_i       (pre_load),
    .load_val_i   (HalfLoad),
    .reload_val_i (FullLoad),
    .tick_o       (tick)
  );

  // Next-state logic for the capture FSM and its datapath.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    pre_load  = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (iSTART) begin
          state_d   = StWaitEdge;
          count_d   = '0;
          wr_addr_d = '0;
          shift_d   = '0;
          bit_cnt_d = '0;
        end
      end
      StWaitEdge: begin
        if (rise) begin
          state_d  = StCapture;
          pre_load = 1'b1;
        end
      end
      StCapture: begin
        if (tick) begin
          shift_d = word_next;
          if (bit_cnt_q == BitLast) begin
            // Word complete: commit it and carry on without re-syncing to an edge.
            mem_we    = 1'b1;
            bit_cnt_d = '0;
            wr_addr_d = wr_addr_q + 1'b1;
            count_d   = count_q + 1'b1;
            if (count_q == CountLast) begin
              state_d = StDone;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StWaitEdge) || (state_d == StCapture);
    done_d = (state_d == StDone);
  end

  // FSM state, datapath registers and registered status outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= StIdle;
      count_q   <= '0;
      wr_addr_q <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Capture RAM write port; contents survive reset.
  always_ff @(posedge iCLK) begin
    if (mem_we) begin
      mem[wr_addr_q] <= word_next;
    end
  end

  // Read sees the pre-write contents when addresses collide.
  always_comb begin
    rd_data_d = mem[iRD_ADDR];
  end

  // Registered read data, one cycle latency.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign oRD_DATA = rd_data_q;
  assign oBUSY    = busy_q;
  assign oDONE    = done_q;
  assign oCOUNT   = count_q;

endmodule

// File: tb/tb_sig_capture_mram.sv
// Self-checking bench for sig_capture_mram with a bit-stream reference model.
module tb_sig_capture_mram;

  localparam int DIV   = 4;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          iCLK = 1'b0;
  logic          iRST_N;
  logic          iSTART;
  logic          iSIG;
  logic [AW-1:0] iRD_ADDR;
  logic [W-1:0]  oRD_DATA;
  logic          oBUSY;
  logic          oDONE;
  logic [AW:0]   oCOUNT;

  int n_checks = 0;
  int n_errors = 0;

  bit           stim_q[$];
  logic [W-1:0] exp_mem [DEPTH];
  int           exp_count;

  sig_capture_mram #(
    .DIV   (DIV),
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iSTART   (iSTART),
    .iSIG     (iSIG),
    .iRD_ADDR (iRD_ADDR),
    .oRD_DATA (oRD_DATA),
    .oBUSY    (oBUSY),
    .oDONE    (oDONE),
    .oCOUNT   (oCOUNT)
  );

  always #5 iCLK = ~iCLK;

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stim_q.push_back(b[i]);
  endtask

  task automatic arm();
    iSTART = 1'b1;
    step();
    iSTART = 1'b0;
  endtask

  // Line-level model: find the first 0->1 transition of the stream (given the level before
  // it), then chop the following bits into MSB-first words. A word counts as stored if at
  // least one full bit period of line activity followed its last bit.
  function automatic int model_run(input bit prev, input int delivered);
    int           first;
    bit           lvl;
    int           n;
    logic [W-1:0] word;
    first = -1;
    lvl   = prev;
    n     = 0;
    foreach (stim_q[i]) begin
      if (first < 0 && stim_q[i] && !lvl) first = i;
      lvl = stim_q[i];
    end
    if (first < 0) return 0;
    for (int w = 0; w < DEPTH; w++) begin
      if (first + (w + 1) * W > delivered - 1) break;
      word = '0;
      for (int b = 0; b < W; b++) word = {word[W-2:0], stim_q[first + w * W + b]};
      exp_mem[w] = word;
      n++;
    end
    return n;
  endfunction

  // Drive each stream bit for DIV cycles; optionally pulse iSTART at one bit.
  task automatic drive_stream(input int nbits, input int start_at);
    for (int i = 0; i < nbits; i++) begin
      iSIG = stim_q[i];
      if (i == start_at) begin
        iSTART = 1'b1;
        step();
        iSTART = 1'b0;
        repeat (DIV - 1) step();
      end else begin
        repeat (DIV) step();
      end
    end
  endtask

  task automatic wait_done();
    for (int k = 0; k < 60 && oDONE !== 1'b1; k++) step();
  endtask

  task automatic test_reset();
    iRST_N   = 1'b0;
    iSTART   = 1'b0;
    iSIG     = 1'b0;
    iRD_ADDR = '0;
    for (int i = 0; i < 8; i++) begin
      iSIG   = ~iSIG;
      iSTART = (i == 3);
      step();
    end
    iSTART = 1'b0;
    n_checks++;
    if (oBUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", oBUSY); end
    n_checks++;
    if (oDONE !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b want 0", oDONE); end
    n_checks++;
    if (oCOUNT !== 3'd0) begin n_errors++; $display("FAIL reset_count got %0d want 0", oCOUNT); end
    n_checks++;
    if (oRD_DATA !== 8'h00) begin
      n_errors++; $display("FAIL reset_rd_data got %h want 00", oRD_DATA);
    end
    iSIG = 1'b0;
    step();
    iRST_N = 1'b1;
    repeat (6) step();
    n_checks++;
    if (oBUSY !== 1'b0) begin n_errors++; $display("FAIL post_reset_busy got %b want 0", oBUSY); end
    n_checks++;
    if (oCOUNT !== 3'd0) begin
      n_errors++; $display("FAIL post_reset_count got %0d want 0", oCOUNT);
    end
  endtask

  task automatic test_basic_capture();
    bit prev;
    prev = iSIG;
    stim_q.delete();
    stim_q.push_back(1'b0);
    stim_q.push_back(1'b0);
    push_byte(8'hA5);
    push_byte(8'h3C);
    push_byte(8'hFF);
    push_byte(8'h01);
    stim_q.push_back(1'b1);
    stim_q.push_back(1'b1);
    arm();
    n_checks++;
    if (oBUSY !== 1'b1) begin n_errors++; $display("FAIL basic_busy got %b want 1", oBUSY); end
    drive_stream(stim_q.size(), -1);
    exp_count = model_run(prev, stim_q.size());
    wait_done();
    n_checks++;
    if (oDONE !== 1'b1) begin n_errors++; $display("FAIL basic_done got %b want 1", oDONE); end
    n_checks++;
    if (oCOUNT !== 3'(exp_count)) begin
      n_errors++; $display("FAIL basic_count got %0d want %0d", oCOUNT, exp_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      iRD_ADDR = AW'(a);
      step();
      n_checks++;
      if (oRD_DATA !== exp_mem[a]) begin
        n_errors++; $display("FAIL basic_rd[%0d] got %h want %h", a, oRD_DATA, exp_mem[a]);
      end
    end
  endtask

  task automatic test_armed_high();
    logic [7:0] b;
    iSIG = 1'b1;
    repeat (3) step();
    arm();
    n_checks++;
    if (oCOUNT !== 3'd0) begin n_errors++; $display("FAIL high_arm_count got %0d want 0", oCOUNT); end
    repeat (20) step();
    n_checks++;
    if (oBUSY !== 1'b1) begin n_errors++; $display("FAIL high_wait_busy got %b want 1", oBUSY); end
    n_checks++;
    if (oCOUNT !== 3'd0 || oDONE !== 1'b0) begin
      n_errors++; $display("FAIL high_wait_state got count=%0d done=%b want 0/0", oCOUNT, oDONE);
    end
    stim_q.delete();
    stim_q.push_back(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      if (i == 0) b[7] = 1'b1;
      push_byte(b);
    end
    stim_q.push_back(stim_q[stim_q.size() - 1]);
    stim_q.push_back(stim_q[stim_q.size() - 1]);
    drive_stream(stim_q.size(), -1);
    exp_count = model_run(1'b1, stim_q.size());
    wait_done();
    n_checks++;
    if (oDONE !== 1'b1 || oCOUNT !== 3'(exp_count)) begin
      n_errors++;
      $display("FAIL high_done got done=%b count=%0d want 1/%0d", oDONE, oCOUNT, exp_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      iRD_ADDR = AW'(a);
      step();
      n_checks++;
      if (oRD_DATA !== exp_mem[a]) begin
        n_errors++; $display("FAIL high_rd[%0d] got %h want %h", a, oRD_DATA, exp_mem[a]);
      end
    end
  endtask

  // Re-arm from DONE; a marker 1 precedes the data to give the edge, and a stray
  // iSTART lands mid-capture.
  task automatic test_rearm();
    bit prev;
    prev = iSIG;
    stim_q.delete();
    stim_q.push_back(1'b0);
    stim_q.push_back(1'b1);
    push_byte(8'h00);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    stim_q.push_back(1'b1);
    stim_q.push_back(1'b1);
    arm();
    n_checks++;
    if (oDONE !== 1'b0 || oCOUNT !== 3'd0) begin
      n_errors++; $display("FAIL rearm_clear got done=%b count=%0d want 0/0", oDONE, oCOUNT);
    end
    drive_stream(stim_q.size(), 12);
    exp_count = model_run(prev, stim_q.size());
    wait_done();
    n_checks++;
    if (oDONE !== 1'b1 || oCOUNT !== 3'(exp_count)) begin
      n_errors++;
      $display("FAIL rearm_done got done=%b count=%0d want 1/%0d", oDONE, oCOUNT, exp_count);
    end
    for (int a = 0; a < DEPTH; a++) begin
      iRD_ADDR = AW'(a);
      step();
      n_checks++;
      if (oRD_DATA !== exp_mem[a]) begin
        n_errors++; $display("FAIL rearm_rd[%0d] got %h want %h", a, oRD_DATA, exp_mem[a]);
      end
    end
  endtask

  task automatic test_collision();
    logic [7:0] b;
    logic [7:0] old2;
    logic [7:0] new2;
    bit         prev;
    prev = iSIG;
    old2 = exp_mem[2];
    stim_q.delete();
    stim_q.push_back(1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      if (i == 0) b[7] = 1'b1;
      if (i == 2) b = old2 ^ 8'($urandom_range(1, 255));
      push_byte(b);
    end
    stim_q.push_back(stim_q[stim_q.size() - 1]);
    stim_q.push_back(stim_q[stim_q.size() - 1]);
    exp_count = model_run(prev, stim_q.size());
    new2 = exp_mem[2];
    iRD_ADDR = 2'd2;
    arm();
    fork
      drive_stream(stim_q.size(), -1);
      begin
        for (int k = 0; k < 400 && oCOUNT !== 3'd3; k++) step();
        n_checks++;
        if (oCOUNT !== 3'd3 || oRD_DATA !== old2) begin
          n_errors++;
          $display("FAIL collide_old got count=%0d data=%h want 3/%h", oCOUNT, oRD_DATA, old2);
        end
        step();
        n_checks++;
        if (oRD_DATA !== new2) begin
          n_errors++; $display("FAIL collide_new got %h want %h", oRD_DATA, new2);
        end
      end
    join
    wait_done();
    n_checks++;
    if (oDONE !== 1'b1 || oCOUNT !== 3'(exp_count)) begin
      n_errors++;
      $display("FAIL collide_done got done=%b count=%0d want 1/%0d", oDONE, oCOUNT, exp_count);
    end
  endtask

  // Reset after one word plus three bits: partial word lost, committed words kept.
  task automatic test_reset_mid();
    bit prev;
    int n;
    prev = iSIG;
    stim_q.delete();
    stim_q.push_back(1'b0);
    push_byte(8'hA5);
    for (int i = 1; i < DEPTH; i++) push_byte(8'($urandom));
    arm();
    drive_stream(12, -1);
    iRST_N = 1'b0;
    #1;
    n = model_run(prev, 12);
    n_checks++;
    if (oBUSY !== 1'b0 || oDONE !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_state got busy=%b done=%b want 0/0", oBUSY, oDONE);
    end
    n_checks++;
    if (oCOUNT !== 3'd0) begin n_errors++; $display("FAIL mid_reset_count got %0d want 0", oCOUNT); end
    n_checks++;
    if (oRD_DATA !== 8'h00) begin
      n_errors++; $display("FAIL mid_reset_rd got %h want 00", oRD_DATA);
    end
    n_checks++;
    if (n !== 1) begin n_errors++; $display("FAIL mid_model_words got %0d want 1", n); end
    iSIG = 1'b0;
    repeat (3) step();
    iRST_N = 1'b1;
    step();
    for (int a = 0; a < DEPTH; a++) begin
      iRD_ADDR = AW'(a);
      step();
      n_checks++;
      if (oRD_DATA !== exp_mem[a]) begin
        n_errors++; $display("FAIL mid_rd[%0d] got %h want %h", a, oRD_DATA, exp_mem[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_armed_high();
    test_rearm();
    test_collision();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
